// File: rtl/ringosc_entropy_sampler.sv
// Ring-oscillator entropy consumer: synchronise, sample, optional von Neumann debias, pack, stream.
// Optional feature macro: RINGOSC_VN_DEBIAS_EN (defined = von Neumann debias on raw sample pairs).
module ringosc_entropy_sampler #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SAMPLE_DIV  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STUCK_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rnd_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail,
    output logic [15:0]      sample_count
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {ACCUM, FULL, FAIL} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            div_q, div_d;
    logic [15:0]            scnt_q, scnt_d;
    logic [15:0]            run_q, run_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   have_q, have_d;
    logic                   first_q, first_d;
    logic                   s, tick, trip, bit_ok, bit_val;

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = (div_q == 16'(SAMPLE_DIV - 1));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rnd_in};
        div_d   = tick ? '0 : div_q + 16'd1;
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        have_d  = have_q;
        first_d = first_q;
        prev_d  = prev_q;
        run_d   = run_q;
        scnt_d  = scnt_q;
        bit_ok  = 1'b0;
        bit_val = 1'b0;

        // Health monitor and sample counter see every tick, stalled or not.
        if (tick) begin
            if (scnt_q != '1) scnt_d = scnt_q + 16'd1;
            prev_d = s;
            if (s != prev_q)       run_d = 16'd1;
            else if (run_q != '1)  run_d = run_q + 16'd1;
        end
        trip = tick && (32'(run_d) >= STUCK_LIMIT);

        if (tick && state_q == ACCUM) begin
`ifdef RINGOSC_VN_DEBIAS_EN
            if (!have_q) begin
                have_d  = 1'b1;
                first_d = s;
            end else begin
                have_d = 1'b0;
                if (first_q != s) begin
                    bit_ok  = 1'b1;
                    bit_val = first_q;
                end
            end
`else
            bit_ok  = 1'b1;
            bit_val = s;
`endif
        end

        case (state_q)
            ACCUM: begin
                if (bit_ok) begin
                    data_d = {data_q[WIDTH-2:0], bit_val};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (tick) have_d = 1'b0;
                if (out_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase

        // A health trip overrides any harvest or handshake in the same cycle.
        if (trip || state_q == FAIL) begin
            state_d = FAIL;
            data_d  = '0;
            cnt_d   = '0;
            have_d  = 1'b0;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            sync_q  <= '0;
            div_q   <= '0;
            scnt_q  <= '0;
            run_q   <= '0;
            prev_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            have_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            run_q   <= run_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            have_q  <= have_d;
            first_q <= first_d;
        end
    end

    assign out_data     = data_q;
    assign out_valid    = (state_q == FULL);
    assign health_fail  = (state_q == FAIL);
    assign sample_count = scnt_q;

endmodule
